// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: parity modes and receive FSM states.
package uart_rx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small synchronous FIFO with show-ahead output; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo_sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, 1/2 stop bits, error
// pulses and a show-ahead receive FIFO so a stalled core does not lose bytes.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 rd_en_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 full_o,
  output logic                 overrun_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e            state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;
  logic                 stop_bad_q;
  logic                 par_bad_q;
  logic                 overrun_q;
  logic                 frame_err_q;
  logic                 parity_err_q;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic frame_last;
  logic stop_any_bad;
  logic parity_bad;
  logic fifo_ready;
  logic push;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign pop          = rd_en_i & ~fifo_empty;
  assign fifo_ready   = ~fifo_full | pop;
  assign frame_last   = (state_q == ST_STOP) && (clk_cnt_q == CNT_LAST) && (bit_cnt_q == STOP_LAST);
  assign stop_any_bad = stop_bad_q | ~rx_s_q;
  assign parity_bad   = (PARITY == PARITY_ODD) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
  assign push         = frame_last & ~stop_any_bad & ~par_bad_q & fifo_ready;

  // Errors are only resolved on the final stop sample, so a frame flags at most one.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop_bad_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s_q) state_q <= ST_START;
        end
        ST_START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q  <= '0;
              stop_bad_q <= 1'b0;
              par_bad_q  <= 1'b0;
              state_q    <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_PAR: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            par_bad_q <= parity_bad;
            state_q   <= ST_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= ST_IDLE;
              if (stop_any_bad)     frame_err_q  <= 1'b1;
              else if (par_bad_q)   parity_err_q <= 1'b1;
              else if (!fifo_ready) overrun_q    <= 1'b1;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 4'd1;
              stop_bad_q <= stop_any_bad;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push_i (push),
    .din_i  (shift_q),
    .pop_i  (pop),
    .dout_o (rd_data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rd_valid_o   = ~fifo_empty;
  assign full_o       = fifo_full;
  assign overrun_o    = overrun_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a no-parity and an even-parity instance at
// 16 clocks per bit, driven from a vector table plus hand-written corner cases.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  typedef struct {
    int         target;
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    logic       expValid;
    logic [7:0] expData;
    int         expFe;
    int         expPe;
    int         expOv;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx0, rx2, rdEn0, rdEn2;
  logic [7:0] rdData0, rdData2;
  logic       rdValid0, rdValid2, full0, full2;
  logic       ov0, ov2, fe0, fe2, pe0, pe2;

  int checks = 0;
  int errors = 0;
  int fe0Cnt = 0, pe0Cnt = 0, ov0Cnt = 0;
  int fe2Cnt = 0, pe2Cnt = 0, ov2Cnt = 0;
  int fe0Base, pe0Base, ov0Base, fe2Base, pe2Base, ov2Base;

  vec_t vecs [9];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .rx_i(rx0), .rd_en_i(rdEn0),
    .rd_data_o(rdData0), .rd_valid_o(rdValid0), .full_o(full0),
    .overrun_o(ov0), .frame_err_o(fe0), .parity_err_o(pe0)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk_i(clk), .reset_i(reset), .rx_i(rx2), .rd_en_i(rdEn2),
    .rd_data_o(rdData2), .rd_valid_o(rdValid2), .full_o(full2),
    .overrun_o(ov2), .frame_err_o(fe2), .parity_err_o(pe2)
  );

  // Count high cycles of every error pulse so a check can compare deltas.
  always @(negedge clk) begin
    if (fe0) fe0Cnt++;
    if (pe0) pe0Cnt++;
    if (ov0) ov0Cnt++;
    if (fe2) fe2Cnt++;
    if (pe2) pe2Cnt++;
    if (ov2) ov2Cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic snapCounters();
    fe0Base = fe0Cnt; pe0Base = pe0Cnt; ov0Base = ov0Cnt;
    fe2Base = fe2Cnt; pe2Base = pe2Cnt; ov2Base = ov2Cnt;
  endtask

  task automatic driveBit(input int target, input logic b);
    if (target == 2) rx2 = b;
    else rx0 = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Start, data LSB first, parity on the parity instance, one stop, two idle bits.
  task automatic sendFrame(input int target, input logic [7:0] data, input logic parBit, input logic stopBit);
    driveBit(target, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(target, data[i]);
    if (target == 2) driveBit(target, parBit);
    driveBit(target, stopBit);
    driveBit(target, 1'b1);
    driveBit(target, 1'b1);
  endtask

  task automatic popHead(input int target);
    if (target == 2) rdEn2 = 1'b1;
    else rdEn0 = 1'b1;
    @(posedge clk);
    #1;
    rdEn0 = 1'b0;
    rdEn2 = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    snapCounters();
    sendFrame(v.target, v.data, v.parBit, v.stopBit);
    @(negedge clk);
    if (v.target == 2) begin
      checkOutput({tag, " rd_valid"}, 32'(rdValid2), 32'(v.expValid));
      if (v.expValid) checkOutput({tag, " rd_data"}, 32'(rdData2), 32'(v.expData));
      checkOutput({tag, " frame_err"}, fe2Cnt - fe2Base, v.expFe);
      checkOutput({tag, " parity_err"}, pe2Cnt - pe2Base, v.expPe);
      checkOutput({tag, " overrun"}, ov2Cnt - ov2Base, v.expOv);
    end else begin
      checkOutput({tag, " rd_valid"}, 32'(rdValid0), 32'(v.expValid));
      if (v.expValid) checkOutput({tag, " rd_data"}, 32'(rdData0), 32'(v.expData));
      checkOutput({tag, " frame_err"}, fe0Cnt - fe0Base, v.expFe);
      checkOutput({tag, " parity_err"}, pe0Cnt - pe0Base, v.expPe);
      checkOutput({tag, " overrun"}, ov0Cnt - ov0Base, v.expOv);
    end
    @(posedge clk);
    #1;
    if (v.expValid) begin
      popHead(v.target);
      @(negedge clk);
      checkOutput({tag, " empty after pop"}, 32'(v.target == 2 ? rdValid2 : rdValid0), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] fillBytes [4];
    fillBytes[0] = 8'h11; fillBytes[1] = 8'h22; fillBytes[2] = 8'h33; fillBytes[3] = 8'h44;

    vecs[0] = '{0, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A, 0, 0, 0};
    vecs[1] = '{0, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0};
    vecs[2] = '{2, 8'h0A, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1, 0};
    vecs[3] = '{2, 8'h0A, 1'b0, 1'b1, 1'b1, 8'h0A, 0, 0, 0};
    vecs[4] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0, 0};
    vecs[5] = '{2, 8'h35, 1'b0, 1'b1, 1'b1, 8'h35, 0, 0, 0};
    vecs[6] = '{2, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 0, 0, 0};
    vecs[7] = '{2, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 0};
    vecs[8] = '{2, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, 0};

    reset = 1'b1; rx0 = 1'b1; rx2 = 1'b1; rdEn0 = 1'b0; rdEn2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset rd_valid", 32'({rdValid0, rdValid2}), 32'd0);
    checkOutput("reset rd_data", 32'({rdData0, rdData2}), 32'd0);
    checkOutput("reset full", 32'({full0, full2}), 32'd0);
    checkOutput("reset flags", 32'({ov0, fe0, pe0, ov2, fe2, pe2}), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) applyStimulus(i);

    // Glitch shorter than half a bit is a false start.
    snapCounters();
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch rd_valid", 32'(rdValid0), 32'd0);
    checkOutput("glitch flags", fe0Cnt + pe0Cnt + ov0Cnt - fe0Base - pe0Base - ov0Base, 32'd0);
    @(posedge clk);
    #1;
    sendFrame(0, 8'h3C, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("after glitch rd_data", 32'(rdData0), 32'h3C);
    @(posedge clk);
    #1;
    popHead(0);

    // Fill the FIFO without reading, then overflow it.
    snapCounters();
    for (int i = 0; i < 4; i++) begin
      sendFrame(0, fillBytes[i], 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("fill%0d full", i), 32'(full0), (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    sendFrame(0, 8'h55, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("overflow overrun", ov0Cnt - ov0Base, 32'd1);
    checkOutput("overflow other flags", fe0Cnt + pe0Cnt - fe0Base - pe0Base, 32'd0);
    checkOutput("overflow full", 32'(full0), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("drain%0d rd_data", i), 32'(rdData0), 32'(fillBytes[i]));
      @(posedge clk);
      #1;
      popHead(0);
    end
    @(negedge clk);
    checkOutput("drained rd_valid", 32'(rdValid0), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of the fourth data bit flushes the FIFO and the frame.
    sendFrame(0, 8'h66, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pre-reset rd_valid", 32'(rdValid0), 32'd1);
    @(posedge clk);
    #1;
    snapCounters();
    driveBit(0, 1'b0);
    for (int i = 0; i < 3; i++) driveBit(0, 1'b0);
    rx0 = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx0 = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-reset rd_valid", 32'(rdValid0), 32'd0);
    checkOutput("mid-reset flags", fe0Cnt + pe0Cnt + ov0Cnt - fe0Base - pe0Base - ov0Base, 32'd0);
    @(posedge clk);
    #1;
    sendFrame(0, 8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("post-reset rd_valid", 32'(rdValid0), 32'd1);
    checkOutput("post-reset rd_data", 32'(rdData0), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
